// File: rtl/connect_four_pkg.sv
// Shared Connect Four definitions: board geometry, cell encodings and the LED scanner states.
package connect_four_pkg;
   localparam int ROWS     = 8;
   localparam int COLS     = 8;
   localparam int ROW_BITS = 3;
   localparam int COL_BITS = 3;

   typedef enum logic [1:0] {
      EMPTY   = 2'b00,
      PLAYER1 = 2'b01,
      PLAYER2 = 2'b10
   } cell_e;

   typedef enum logic {
      FETCH   = 1'b0,
      DISPLAY = 1'b1
   } scanState_e;
endpackage

// File: rtl/led_line_buffer.sv
// One board row of cells captured from the read bus, mapped to red/green column drives.
module led_line_buffer
   import connect_four_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wrEn_i,
   input  logic [COL_BITS-1:0] wrCol_i,
   input  logic [1:0]          wrData_i,
   input  logic                cursorEn_i,
   input  logic [COL_BITS-1:0] cursorCol_i,
   input  logic [1:0]          cursorPlayer_i,
   input  logic                hidePieces_i,
   output logic [COLS-1:0]     red_o,
   output logic [COLS-1:0]     green_o
);
   logic [COLS-1:0][1:0] cells_q;
   logic [COLS-1:0][1:0] cells_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cells_q <= '0;
      end else begin
         cells_q <= cells_d;
      end
   end

   always_comb begin
      cells_d = cells_q;
      if (wrEn_i) begin
         cells_d[wrCol_i] = wrData_i;
      end
   end

   // Mapping looks at the next-state cells so the last capture of a fetch is already included.
   always_comb begin
      red_o   = '0;
      green_o = '0;
      if (!hidePieces_i) begin
         for (int c = 0; c < COLS; c++) begin
            red_o[c]   = cells_d[c][0];
            green_o[c] = cells_d[c][1];
         end
      end
      if (cursorEn_i && (cells_d[cursorCol_i] == EMPTY)) begin
         red_o[cursorCol_i]   = cursorPlayer_i[0];
         green_o[cursorCol_i] = cursorPlayer_i[1];
      end
   end
endmodule

// File: rtl/board_led_scanner.sv
// Row-multiplexed LED scanner: fetches one board row over the game read bus, then lights it.
module board_led_scanner
   import connect_four_pkg::*;
#(
   parameter int DWELL_CYCLES = 1024,
   parameter int BLINK_FRAMES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [ROW_BITS-1:0] row_read,
   output logic [COL_BITS-1:0] col_read,
   input  logic [1:0]          data_in,
   input  logic                bus_valid,
   input  logic                game_over,
   input  logic [COL_BITS-1:0] current_col,
   input  logic [1:0]          current_player,
   output logic [ROWS-1:0]     led_row,
   output logic [COLS-1:0]     led_red,
   output logic [COLS-1:0]     led_green,
   output logic                frame_start
);
   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

   scanState_e          state_q, state_d;
   logic [ROW_BITS-1:0] scanRow_q, scanRow_d;
   logic [3:0]          fetchCnt_q, fetchCnt_d;
   logic [DWELL_W-1:0]  dwellCnt_q, dwellCnt_d;
   logic [FRAME_W-1:0]  frameCnt_q, frameCnt_d;
   logic                blink_q, blink_d;
   logic                rowFresh_q, rowFresh_d;
   logic [ROWS-1:0]     ledRow_q, ledRow_d;
   logic [COLS-1:0]     ledRed_q, ledRed_d;
   logic [COLS-1:0]     ledGreen_q, ledGreen_d;
   logic                fetchDone, dwellDone, captureEn;
   logic [COLS-1:0]     mapRed, mapGreen;

   assign fetchDone = (state_q == FETCH) && bus_valid && (fetchCnt_q == 4'd8);
   assign dwellDone = (state_q == DISPLAY) && (dwellCnt_q == DWELL_LAST);
   assign captureEn = (state_q == FETCH) && bus_valid && (fetchCnt_q != 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         scanRow_q  <= '0;
         fetchCnt_q <= '0;
         dwellCnt_q <= '0;
         frameCnt_q <= '0;
         blink_q    <= 1'b0;
         rowFresh_q <= 1'b1;
         ledRow_q   <= '0;
         ledRed_q   <= '0;
         ledGreen_q <= '0;
      end else begin
         state_q    <= state_d;
         scanRow_q  <= scanRow_d;
         fetchCnt_q <= fetchCnt_d;
         dwellCnt_q <= dwellCnt_d;
         frameCnt_q <= frameCnt_d;
         blink_q    <= blink_d;
         rowFresh_q <= rowFresh_d;
         ledRow_q   <= ledRow_d;
         ledRed_q   <= ledRed_d;
         ledGreen_q <= ledGreen_d;
      end
   end

   // A low bus_valid spoils either this address or this data beat, so the fetch starts over.
   always_comb begin
      state_d    = state_q;
      scanRow_d  = scanRow_q;
      fetchCnt_d = fetchCnt_q;
      dwellCnt_d = dwellCnt_q;
      frameCnt_d = frameCnt_q;
      blink_d    = blink_q;
      rowFresh_d = rowFresh_q;
      case (state_q)
         FETCH: begin
            rowFresh_d = 1'b0;
            dwellCnt_d = '0;
            if (!bus_valid || fetchDone) begin
               fetchCnt_d = '0;
            end else begin
               fetchCnt_d = fetchCnt_q + 4'd1;
            end
            if (fetchDone) begin
               state_d = DISPLAY;
            end
         end
         DISPLAY: begin
            dwellCnt_d = dwellCnt_q + 1'b1;
            if (dwellDone) begin
               state_d    = FETCH;
               dwellCnt_d = '0;
               scanRow_d  = scanRow_q + 1'b1;
               rowFresh_d = 1'b1;
               if (scanRow_q == ROW_BITS'(ROWS - 1)) begin
                  if (frameCnt_q == FRAME_LAST) begin
                     frameCnt_d = '0;
                     blink_d    = !blink_q;
                  end else begin
                     frameCnt_d = frameCnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      row_read    = scanRow_q;
      col_read    = (state_q == FETCH) ? fetchCnt_q[2:0] : '0;
      frame_start = rst_n && (state_q == FETCH) && (scanRow_q == '0) && rowFresh_q;
      ledRow_d    = ledRow_q;
      ledRed_d    = ledRed_q;
      ledGreen_d  = ledGreen_q;
      if (fetchDone) begin
         ledRow_d   = ROWS'(1) << scanRow_q;
         ledRed_d   = mapRed;
         ledGreen_d = mapGreen;
      end else if (dwellDone) begin
         ledRow_d   = '0;
         ledRed_d   = '0;
         ledGreen_d = '0;
      end
   end

   assign led_row   = ledRow_q;
   assign led_red   = ledRed_q;
   assign led_green = ledGreen_q;

   led_line_buffer u_lineBuffer (
      .clk            (clk),
      .rst_n          (rst_n),
      .wrEn_i         (captureEn),
      .wrCol_i        (fetchCnt_q[2:0] - 3'd1),
      .wrData_i       (data_in),
      .cursorEn_i     ((scanRow_q == ROW_BITS'(ROWS - 1)) && !game_over && blink_q),
      .cursorCol_i    (current_col),
      .cursorPlayer_i (current_player),
      .hidePieces_i   (game_over && !blink_q),
      .red_o          (mapRed),
      .green_o        (mapGreen)
   );
endmodule

// File: doc/board_led_scanner.md
BOARD_LED_SCANNER -- requirements
Module: board_led_scanner

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1024, the number of clocks each display row is lit (>=1).
REQ-002 SHALL have parameter BLINK_FRAMES, default 16, the number of frames per blink-phase toggle (>=1).
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port row_read, output, 3 bits: board row address driven to the game block.
REQ-006 SHALL have port col_read, output, 3 bits: board column address driven to the game block.
REQ-007 SHALL have port data_in, input, 2 bits: cell contents returned one clock after the address (00 empty, 01 P1, 10 P2).
REQ-008 SHALL have port bus_valid, input, 1 bit: high when the game block routes row_read/col_read to the board (game FSM idle or win).
REQ-009 SHALL have ports game_over, input, 1 bit; current_col, input, 3 bits; current_player, input, 2 bits: game status.
REQ-010 SHALL have port led_row, output, 8 bits: one-hot row enable, active-high; bit r = board row r.
REQ-011 SHALL have ports led_red and led_green, output, 8 bits each: column drives, bit c = column c.
REQ-012 SHALL have port frame_start, output, 1 bit: one-clock pulse when a fetch of row 0 begins.

Function
REQ-013 SHALL implement FSM states FETCH and DISPLAY; reset state FETCH with scan_row=0.
REQ-014 FETCH SHALL drive row_read=scan_row and col_read=0..7 on consecutive clocks, capture data_in one clock after each address, and occupy 9 clocks (8 addresses plus 1 drain).
REQ-015 A capture SHALL count only if bus_valid was high in both the address clock and the data clock; otherwise the fetch restarts at col 0 on the next clock.
REQ-016 During FETCH, led_row, led_red and led_green SHALL be 0 (blanked).
REQ-017 After the 9th FETCH clock, the FSM SHALL enter DISPLAY, load the 8-cell line buffer into the output registers, and hold for exactly DWELL_CYCLES clocks.
REQ-018 During DISPLAY, led_row SHALL be 1<<scan_row, with outputs registered.
REQ-019 Colour map SHALL be: 01 -> red, 10 -> green, 11 -> red and green, 00 -> off.
REQ-020 Cursor: on scan_row 7 with game_over=0, if cell[current_col] is empty and blink=1, column current_col SHALL show the current_player colour.
REQ-021 When game_over=1, all piece LEDs SHALL be forced off while blink=0, and the cursor SHALL be suppressed.
REQ-022 At DISPLAY end, scan_row SHALL increment, wrapping from 7 to 0, and the FSM SHALL return to FETCH.
REQ-023 frame_start SHALL pulse in the first FETCH clock of row 0, including the first clock after reset release.
REQ-024 A frame counter SHALL count frame_start pulses modulo BLINK_FRAMES; blink SHALL toggle on each wrap; blink resets to 0.
REQ-025 current_col, current_player and game_over SHALL be sampled on the first DISPLAY clock and held for that row.
REQ-026 Frame period SHALL be 8*(9+DWELL_CYCLES) clocks when bus_valid stays high.

Reset
REQ-027 Asserting rst_n low SHALL immediately set: FSM=FETCH, scan_row=0, col counter=0, dwell counter=0, frame counter=0, blink=0, line buffer=0, led_*=0, frame_start=0, row_read=0, col_read=0.
REQ-028 Reset asserted mid-FETCH or mid-DISPLAY SHALL abandon the row; no partial line SHALL be displayed after release.

Structure
REQ-029 Cell encodings (EMPTY/PLAYER1/PLAYER2), ROWS/COLS=8 and ROW_BITS/COL_BITS=3 SHALL live in the shared connect_four package used by the game block.
REQ-030 The block SHALL contain one sub-module, led_line_buffer (8x2-bit capture register with colour/cursor/blink mapping); FSM and counters SHALL remain in board_led_scanner.

Verification
REQ-031 Board model with cells (r0,c0)=01 and (r0,c7)=10, DWELL_CYCLES=4, bus_valid=1 -> row 0 DISPLAY shows led_row=0x01, led_red=0x01, led_green=0x80; frame period is 104 clocks.
REQ-032 bus_valid dropped for one clock during the col 5 address of row 3 -> fetch restarts at col 0, DISPLAY is delayed accordingly, and the displayed data matches the model exactly.
REQ-033 Empty row 7, current_col=4, current_player=10, BLINK_FRAMES=2 -> led_green[4] is 0 during frames 0-1 and 1 during frames 2-3; a row 7 piece at col 4 suppresses the cursor.
REQ-034 game_over=1 with a full row 2 of 01 -> led_red=0xFF and 0x00 in alternate blink phases; the cursor never appears.
REQ-035 scan_row=7 wrap -> next fetch has row_read=0 and frame_start pulses exactly once per frame.
REQ-036 rst_n pulsed low mid-DISPLAY of row 5 -> all outputs 0 asynchronously; after release, FETCH of row 0 begins with frame_start=1.
